// File: rtl/fp_add_post_if.sv
// Handshake and data bundle between the operand preparer and the post-alignment
// adder stage.
interface fp_add_post_if;
  logic        in_valid;
  logic        in_ready;
  logic        NaN_res;
  logic        inf_res;
  logic        res_sig;
  logic        legal;
  logic [7:0]  exp_max;
  logic [49:0] mant_op_1;
  logic [49:0] mant_op_2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        out_ovf;
  logic        out_inexact;

  modport master (
    output in_valid, NaN_res, inf_res, res_sig, legal, exp_max,
           mant_op_1, mant_op_2, out_ready,
    input  in_ready, out_valid, result, out_ovf, out_inexact
  );

  modport slave (
    input  in_valid, NaN_res, inf_res, res_sig, legal, exp_max,
           mant_op_1, mant_op_2, out_ready,
    output in_ready, out_valid, result, out_ovf, out_inexact
  );
endinterface

// File: rtl/fp_add_post.sv
// Single-precision adder back end: mantissa add, one-bit-per-cycle normalise,
// round-to-nearest-even and binary32 packing; one operation in flight.
module fp_add_post (
  input  logic         clk,
  input  logic         rst,
  fp_add_post_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ADD, NORM, ROUND, DONE} state_t;
  state_t state, state_nx;

  logic signed [49:0] m1_p0, m2_p0;
  logic [7:0]         exp_p0;
  logic               sig_p0, zero_p0;
  logic [48:0]        mag_p1;
  logic [9:0]         exp_p1;
  logic [31:0]        result_p2;
  logic               ovf_p2, inexact_p2;

  logic signed [49:0] sum_add;
  logic [48:0]        abs_add, mag_add, mag_norm;
  logic [9:0]         e_base, exp_add, exp_norm, exp_rnd;
  logic [25:0]        rnd;
  logic [23:0]        mant_rnd;
  logic [32:0]        packed_rnd;
  logic [31:0]        res_rnd, res_byp;
  logic               ovf_rnd, inexact_rnd;

  // Returns {inexact, 25-bit rounded mantissa incl. carry-out}.
  function automatic logic [25:0] round_rne(input logic [47:0] m);
    logic g, s, inc;
    g   = m[23];
    s   = |m[22:0];
    inc = g & (s | m[24]);
    return {g | s, {1'b0, m[47:24]} + {24'd0, inc}};
  endfunction

  // Returns {ovf, packed word}; exponents past the finite range saturate to infinity.
  function automatic logic [32:0] sat_pack(input logic sig, input logic [9:0] e,
                                           input logic [23:0] mant);
    if (e >= 10'd255) return {1'b1, sig, 8'hFF, 23'h0};
    return {1'b0, sig, (mant[23] ? e[7:0] : 8'h00), mant[22:0]};
  endfunction

  always_comb begin
    sum_add  = m1_p0 + m2_p0;
    abs_add  = sum_add[49] ? 49'(-sum_add) : 49'(sum_add);
    e_base   = (exp_p0 == 8'd0) ? 10'd1 : {2'b00, exp_p0};
    // A carry into the headroom bit is folded back with the lost bit kept sticky.
    if (abs_add[48]) begin
      mag_add = {1'b0, abs_add[48:2], abs_add[1] | abs_add[0]};
      exp_add = e_base + 10'd1;
    end else begin
      mag_add = abs_add;
      exp_add = e_base;
    end

    mag_norm = {mag_p1[47:0], 1'b0};
    exp_norm = exp_p1 - 10'd1;

    rnd = round_rne(mag_p1[47:0]);
    if (rnd[24]) begin
      mant_rnd = 24'h800000;
      exp_rnd  = exp_p1 + 10'd1;
    end else begin
      mant_rnd = rnd[23:0];
      exp_rnd  = exp_p1;
    end
    packed_rnd = sat_pack(sig_p0, exp_rnd, mant_rnd);

    // Exact zero is +0 unless both addends were themselves zero.
    if (mag_p1 == '0) begin
      res_rnd     = {sig_p0 & zero_p0, 31'h0};
      ovf_rnd     = 1'b0;
      inexact_rnd = 1'b0;
    end else begin
      res_rnd     = packed_rnd[31:0];
      ovf_rnd     = packed_rnd[32];
      inexact_rnd = rnd[25];
    end

    if (bus.NaN_res)      res_byp = 32'h7FC00000;
    else if (bus.inf_res) res_byp = {bus.res_sig, 8'hFF, 23'h0};
    else                  res_byp = {bus.res_sig, 31'h0};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = bus.legal ? ADD : DONE;
      ADD:     state_nx = (mag_add != '0 && !mag_add[47] && exp_add > 10'd1) ? NORM : ROUND;
      NORM:    state_nx = (!mag_norm[47] && exp_norm > 10'd1) ? NORM : ROUND;
      ROUND:   state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m1_p0      <= '0;
      m2_p0      <= '0;
      exp_p0     <= '0;
      sig_p0     <= 1'b0;
      zero_p0    <= 1'b0;
      mag_p1     <= '0;
      exp_p1     <= '0;
      result_p2  <= '0;
      ovf_p2     <= 1'b0;
      inexact_p2 <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        // capture stage
        IDLE: if (bus.in_valid) begin
          m1_p0   <= signed'(bus.mant_op_1);
          m2_p0   <= signed'(bus.mant_op_2);
          exp_p0  <= bus.exp_max;
          sig_p0  <= bus.res_sig;
          zero_p0 <= (bus.mant_op_1 == '0) && (bus.mant_op_2 == '0);
          if (!bus.legal) begin
            result_p2  <= res_byp;
            ovf_p2     <= 1'b0;
            inexact_p2 <= 1'b0;
          end
        end
        // add / normalise stage
        ADD: begin
          mag_p1 <= mag_add;
          exp_p1 <= exp_add;
        end
        NORM: begin
          mag_p1 <= mag_norm;
          exp_p1 <= exp_norm;
        end
        // round / pack stage
        ROUND: begin
          result_p2  <= res_rnd;
          ovf_p2     <= ovf_rnd;
          inexact_p2 <= inexact_rnd;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.result      = result_p2;
  assign bus.out_ovf     = ovf_p2;
  assign bus.out_inexact = inexact_p2;

endmodule

// File: tb/tb_fp_add_post.sv
// Bench for fp_add_post: directed vectors with literal expectations plus a
// per-cycle scoreboard driven by an arithmetic reference model.
module tb_fp_add_post;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [49:0] ONE = 50'h0800000000000;
  localparam logic [49:0] ULP = 50'd1 << 24;
  localparam logic [49:0] GRD = 50'd1 << 23;

  fp_add_post_if bus();
  fp_add_post dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: exact sum, leading-one normalisation bounded by the exponent floor,
  // then nearest-even rounding by comparing the discarded remainder with one half.
  function automatic void model(input logic lg, nan, inf, sig, input logic [7:0] ex,
                                input logic [49:0] a, b, output logic [31:0] r,
                                output logic ovf, inex, output int lat);
    logic signed [49:0] sa, sb;
    longint s, mag, keep, rem;
    int e, p, sh;
    logic [7:0] efld;
    ovf = 1'b0; inex = 1'b0;
    if (!lg) begin
      r   = nan ? 32'h7FC00000 : (inf ? {sig, 8'hFF, 23'h0} : {sig, 31'h0});
      lat = 1;
      return;
    end
    sa = a; sb = b;
    s   = longint'(sa) + longint'(sb);
    mag = (s < 0) ? -s : s;
    e   = (ex == 8'd0) ? 1 : int'(ex);
    if (mag >= (longint'(1) << 48)) begin
      mag = (mag >> 1) | (mag & 1);
      e   = e + 1;
    end
    sh = 0;
    if (mag != 0) begin
      p = 0;
      for (int i = 0; i < 49; i++) if (mag[i]) p = i;
      sh = 47 - p;
      if (sh > e - 1) sh = e - 1;
      if (sh < 0) sh = 0;
      mag = mag << sh;
      e   = e - sh;
    end
    lat  = 3 + sh;
    keep = mag >> 24;
    rem  = mag & 64'hFFFFFF;
    if (rem > 64'h800000 || (rem == 64'h800000 && keep[0])) keep = keep + 1;
    inex = (rem != 0);
    if (keep == (longint'(1) << 24)) begin
      keep = longint'(1) << 23;
      e    = e + 1;
    end
    if (mag == 0) begin
      r    = {sig && a == '0 && b == '0, 31'h0};
      inex = 1'b0;
    end else if (e >= 255) begin
      r   = {sig, 8'hFF, 23'h0};
      ovf = 1'b1;
    end else begin
      efld = (keep >= (longint'(1) << 23)) ? 8'(e) : 8'h00;
      r    = {sig, efld, keep[22:0]};
    end
  endfunction

  typedef struct {
    logic [31:0] r;
    logic        ovf;
    logic        inex;
    int          due;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin : compare
    exp_t t;
    logic [31:0] mr;
    logic mo, mx;
    int ml;
    bit exp_vld;
    if (rst) begin
      q.delete();
    end else begin
      chk("in_ready", 32'(bus.in_ready), 32'(q.size() == 0));
      exp_vld = (q.size() > 0) && (cyc >= q[0].due);
      chk("out_valid", 32'(bus.out_valid), 32'(exp_vld));
      if (bus.out_valid && q.size() > 0) begin
        chk("model result", bus.result, q[0].r);
        chk("model ovf", 32'(bus.out_ovf), 32'(q[0].ovf));
        chk("model inexact", 32'(bus.out_inexact), 32'(q[0].inex));
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        model(bus.legal, bus.NaN_res, bus.inf_res, bus.res_sig, bus.exp_max,
              bus.mant_op_1, bus.mant_op_2, mr, mo, mx, ml);
        t.r = mr; t.ovf = mo; t.inex = mx; t.due = cyc + ml;
        q.push_back(t);
      end
    end
  end

  task automatic send(input logic lg, nan, inf, sig, input logic [7:0] ex,
                      input logic [49:0] a, b, output int acc);
    bit ok;
    ok = 0;
    acc = -1;
    bus.legal = lg; bus.NaN_res = nan; bus.inf_res = inf; bus.res_sig = sig;
    bus.exp_max = ex; bus.mant_op_1 = a; bus.mant_op_2 = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = cyc;
        ok  = 1;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!ok) chk("accept timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input string name, input logic lg, nan, inf, sig,
                         input logic [7:0] ex, input logic [49:0] a, b,
                         input logic [31:0] er, input logic eo, ei, input int elat);
    int acc;
    bit got;
    send(lg, nan, inf, sig, ex, a, b, acc);
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1;
        chk({name, " result"}, bus.result, er);
        chk({name, " ovf"}, 32'(bus.out_ovf), 32'(eo));
        chk({name, " inexact"}, 32'(bus.out_inexact), 32'(ei));
        chk({name, " latency"}, 32'(cyc - acc), 32'(elat));
      end
    end
    if (!got) chk({name, " timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int acc;
    bit got;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.legal = 1'b0;
    bus.NaN_res = 1'b0; bus.inf_res = 1'b0; bus.res_sig = 1'b0;
    bus.exp_max = 8'd0; bus.mant_op_1 = '0; bus.mant_op_2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result", bus.result, 32'h0);
    chk("reset ovf", 32'(bus.out_ovf), 32'd0);
    chk("reset inexact", 32'(bus.out_inexact), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    run_vec("ovf_shift",   1'b1, 1'b0, 1'b0, 1'b0, 8'd127, ONE, ONE, 32'h40000000, 1'b0, 1'b0, 3);
    run_vec("cancel",      1'b1, 1'b0, 1'b0, 1'b0, 8'd127, ONE, -(ONE - ULP), 32'h34000000, 1'b0, 1'b0, 26);
    run_vec("rne_tie",     1'b1, 1'b0, 1'b0, 1'b0, 8'd127, ONE + GRD, '0, 32'h3F800000, 1'b0, 1'b1, 3);
    run_vec("rne_up",      1'b1, 1'b0, 1'b0, 1'b0, 8'd127, ONE + ULP + GRD, '0, 32'h3F800002, 1'b0, 1'b1, 3);
    run_vec("to_inf",      1'b1, 1'b0, 1'b0, 1'b0, 8'd254, ONE + (ONE >> 1), ONE + (ONE >> 1), 32'h7F800000, 1'b1, 1'b0, 3);
    run_vec("byp_nan",     1'b0, 1'b1, 1'b0, 1'b0, 8'd0, '0, '0, 32'h7FC00000, 1'b0, 1'b0, 1);
    run_vec("byp_inf",     1'b0, 1'b0, 1'b1, 1'b1, 8'd0, '0, '0, 32'hFF800000, 1'b0, 1'b0, 1);
    run_vec("negative",    1'b1, 1'b0, 1'b0, 1'b1, 8'd127, -(ONE + (ONE >> 1)), '0, 32'hBFC00000, 1'b0, 1'b0, 3);
    run_vec("rnd_carry",   1'b1, 1'b0, 1'b0, 1'b0, 8'd127, (ONE << 1) - ULP + GRD, '0, 32'h40000000, 1'b0, 1'b1, 3);
    run_vec("denorm",      1'b1, 1'b0, 1'b0, 1'b0, 8'd0, ONE >> 1, '0, 32'h00400000, 1'b0, 1'b0, 3);
    run_vec("denorm_up",   1'b1, 1'b0, 1'b0, 1'b0, 8'd0, ONE - ULP + GRD + (GRD >> 1), '0, 32'h00800000, 1'b0, 1'b1, 3);
    run_vec("zero_neg",    1'b1, 1'b0, 1'b0, 1'b1, 8'd0, '0, '0, 32'h80000000, 1'b0, 1'b0, 3);
    run_vec("cancel_zero", 1'b1, 1'b0, 1'b0, 1'b1, 8'd127, ONE, -ONE, 32'h00000000, 1'b0, 1'b0, 3);
    run_vec("norm_floor",  1'b1, 1'b0, 1'b0, 1'b0, 8'd2, ONE >> 3, '0, 32'h00200000, 1'b0, 1'b0, 4);

    // Backpressure: result held while a competing request is presented.
    bus.out_ready = 1'b0;
    send(1'b1, 1'b0, 1'b0, 1'b0, 8'd127, ONE, ONE, acc);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1;
    end
    chk("bp valid seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.legal = 1'b0; bus.NaN_res = 1'b1; bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp result", bus.result, 32'h40000000);
      chk("bp in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of normalisation.
    send(1'b1, 1'b0, 1'b0, 1'b0, 8'd127, ONE, -(ONE - ULP), acc);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort result", bus.result, 32'h0);
    got = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) got = 1;
    end
    chk("abort no result", 32'(got), 32'd0);
    @(posedge clk); #1;

    run_vec("after_abort", 1'b1, 1'b0, 1'b0, 1'b0, 8'd127, ONE + ULP + GRD, '0, 32'h3F800002, 1'b0, 1'b1, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
